// File: rtl/freq_meter_pkg.sv
// Shared widths and types for the frequency-meter stream path.
`default_nettype none

package freq_meter_pkg;
  localparam int AXI_DATA_W  = 32;
  localparam int COUNT_W_DEF = 16;

  typedef logic [COUNT_W_DEF-1:0] count_t;
endpackage

`default_nettype wire

// File: rtl/axi_if.sv
// Single-beat AXI-Stream link between the counter path and its consumers.
`default_nettype none

interface axi_if
  import freq_meter_pkg::*;
#(
  parameter int DATA_W = AXI_DATA_W
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; rdata is the head entry (show-ahead).
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] wdata,
  output logic      [WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

`default_nettype wire

// File: rtl/axis_count_receiver.sv
// Stream sink for count packets: buffers counts, tracks latest value, packet count and error flags.
`default_nettype none

module axis_count_receiver
  import freq_meter_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int PKT_CNT_W = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  axi_if.slave                      axi,
  output logic      [COUNT_W-1:0]   count_data,
  output logic                      count_valid,
  input  wire logic                 count_ready,
  output logic      [COUNT_W-1:0]   last_count,
  output logic      [PKT_CNT_W-1:0] pkt_cnt,
  output logic                      fmt_err,
  input  wire logic                 err_clr,
  output logic                      overflow
);
  logic                 rdy_en_q;
  logic [COUNT_W-1:0]   last_q, last_d;
  logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
  logic                 fmt_q, fmt_d;
  logic                 ovf_q, ovf_d;
  logic                 stall_q, stall_d;
  logic                 fifo_full, fifo_empty;
  logic [COUNT_W-1:0]   fifo_rdata;
  logic                 accept, pop, stall_now, bad_beat;

  // Ready is held low for the first cycle out of reset, then tracks fullness only.
  assign axi.tready = rdy_en_q & ~fifo_full;
  assign accept     = axi.tvalid & axi.tready;
  assign stall_now  = axi.tvalid & ~axi.tready;
  assign bad_beat   = ~axi.tlast | ((axi.tdata >> COUNT_W) != '0);

  assign count_valid = ~fifo_empty;
  assign count_data  = fifo_empty ? '0 : fifo_rdata;
  assign pop         = count_valid & count_ready;
  assign last_count  = last_q;
  assign pkt_cnt     = pkt_q;
  assign fmt_err     = fmt_q;
  assign overflow    = ovf_q;

  sync_fifo #(
    .WIDTH (COUNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (axi.tdata[COUNT_W-1:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A new error in the same cycle as err_clr wins over the clear.
  always_comb begin
    last_d  = last_q;
    pkt_d   = pkt_q;
    if (accept) begin
      last_d = axi.tdata[COUNT_W-1:0];
      pkt_d  = pkt_q + PKT_CNT_W'(1);
    end
    fmt_d   = (accept & bad_beat) | (fmt_q & ~err_clr);
    ovf_d   = (stall_now & stall_q) | (ovf_q & ~err_clr);
    stall_d = stall_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en_q <= 1'b0;
      last_q   <= '0;
      pkt_q    <= '0;
      fmt_q    <= 1'b0;
      ovf_q    <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      last_q   <= last_d;
      pkt_q    <= pkt_d;
      fmt_q    <= fmt_d;
      ovf_q    <= ovf_d;
      stall_q  <= stall_d;
    end
  end
endmodule

`default_nettype wire
